// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared integer-core sizing and writeback source indices
package rv_pkg;
  localparam int WORD_SIZE = 32;
  localparam int NUM_REGS  = 32;
  localparam int REG_SEL   = $clog2(NUM_REGS);

  localparam int SRC_ALU  = 0;
  localparam int SRC_LOAD = 1;
  localparam int SRC_CSR  = 2;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant with a rotating priority pointer
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);
  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic [PW-1:0] gidx;
  logic          found;
  int            pos;

  // Walk ptr, ptr+1, ... modulo N; the first requester wins.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    pos   = 0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      idx = PW'(pos);
      if (!found && req[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
    if (found && rst) grant[gidx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter, registered register-file write port and busy scoreboard
module wb_arbiter #(
  parameter int WORD_SIZE = rv_pkg::WORD_SIZE,
  parameter int NUM_REGS  = rv_pkg::NUM_REGS,
  parameter int REG_SEL   = $clog2(NUM_REGS),
  parameter int NUM_SRC   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC-1:0]           srcValid,
  input  logic [NUM_SRC*REG_SEL-1:0]   srcSel,
  input  logic [NUM_SRC*WORD_SIZE-1:0] srcData,
  output logic [NUM_SRC-1:0]           srcReady,
  input  logic                         issueValid,
  input  logic [REG_SEL-1:0]           issueRd,
  output logic [NUM_REGS-1:0]          busy,
  output logic                         wCtrl,
  output logic [REG_SEL-1:0]           wSel,
  output logic [WORD_SIZE-1:0]         wData
);
  import rv_pkg::*;

  logic [NUM_SRC-1:0]   grant;
  logic                 any_grant;
  logic [REG_SEL-1:0]   gsel;
  logic [WORD_SIZE-1:0] gdata;
  logic [NUM_REGS-1:0]  busy_next;

  rr_arbiter #(.N(NUM_SRC)) u_rr (
    .clk   (clk),
    .rst   (rst),
    .req   (srcValid),
    .grant (grant)
  );

  assign srcReady  = grant;
  assign any_grant = |grant;

  always_comb begin
    gsel  = '0;
    gdata = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        gsel  = srcSel[i*REG_SEL +: REG_SEL];
        gdata = srcData[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  // Clear first so a same-edge issue to the same register keeps it busy.
  always_comb begin
    busy_next = busy;
    if (wCtrl) busy_next[wSel] = 1'b0;
    if (issueValid && (issueRd != '0)) busy_next[issueRd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wCtrl <= 1'b0;
      wSel  <= '0;
      wData <= '0;
      busy  <= '0;
    end else begin
      busy  <= busy_next;
      wCtrl <= any_grant && (gsel != '0);
      if (any_grant) begin
        wSel  <= gsel;
        wData <= gdata;
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed and randomized checks of wb_arbiter against a behavioural model
module tb_wb_arbiter;
  localparam int W  = 32;
  localparam int NR = 32;
  localparam int RS = 5;
  localparam int NS = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS-1:0]     srcValid;
  logic [NS*RS-1:0]  srcSel;
  logic [NS*W-1:0]   srcData;
  logic [NS-1:0]     srcReady;
  logic              issueValid;
  logic [RS-1:0]     issueRd;
  logic [NR-1:0]     busy;
  logic              wCtrl;
  logic [RS-1:0]     wSel;
  logic [W-1:0]      wData;

  int checks = 0;
  int errors = 0;

  int          m_ptr;
  logic        m_wctrl;
  logic [RS-1:0] m_wsel;
  logic [W-1:0]  m_wdata;
  logic [NR-1:0] m_busy;
  int          last_g;

  wb_arbiter #(.WORD_SIZE(W), .NUM_REGS(NR), .REG_SEL(RS), .NUM_SRC(NS)) dut (
    .clk        (clk),
    .rst        (rst),
    .srcValid   (srcValid),
    .srcSel     (srcSel),
    .srcData    (srcData),
    .srcReady   (srcReady),
    .issueValid (issueValid),
    .issueRd    (issueRd),
    .busy       (busy),
    .wCtrl      (wCtrl),
    .wSel       (wSel),
    .wData      (wData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_grant();
    if (!rst) return -1;
    for (int k = 0; k < NS; k++) begin
      int i;
      i = (m_ptr + k) % NS;
      if (srcValid[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_src(input int i, input logic v, input logic [RS-1:0] s, input logic [W-1:0] d);
    srcValid[i]          = v;
    srcSel[i*RS +: RS]   = s;
    srcData[i*W +: W]    = d;
  endtask

  // One clock: check the combinational grant, advance the model, check registered outputs.
  task automatic step();
    int g;
    logic [NS-1:0] eg;
    logic [NR-1:0] nb;
    #1;
    g  = model_grant();
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("srcReady", 64'(srcReady), 64'(eg));
    @(posedge clk);
    if (!rst) begin
      m_ptr = 0; m_wctrl = 0; m_wsel = '0; m_wdata = '0; m_busy = '0;
    end else begin
      nb = m_busy;
      if (m_wctrl) nb[m_wsel] = 1'b0;
      if (issueValid && issueRd != 0) nb[issueRd] = 1'b1;
      m_busy = nb;
      if (g >= 0) begin
        m_wsel  = srcSel[g*RS +: RS];
        m_wdata = srcData[g*W +: W];
        m_wctrl = (m_wsel != 0);
        m_ptr   = (g + 1) % NS;
      end else begin
        m_wctrl = 1'b0;
      end
    end
    last_g = g;
    #1;
    chk("wCtrl", 64'(wCtrl), 64'(m_wctrl));
    chk("wSel", 64'(wSel), 64'(m_wsel));
    chk("wData", 64'(wData), 64'(m_wdata));
    chk("busy", 64'(busy), 64'(m_busy));
  endtask

  initial begin
    logic [NS-1:0] order [6];
    order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    m_ptr = 0; m_wctrl = 0; m_wsel = '0; m_wdata = '0; m_busy = '0; last_g = -1;
    rst = 1'b0; issueValid = 1'b0; issueRd = '0;
    srcValid = '0; srcSel = '0; srcData = '0;

    // Reset with every source requesting
    set_src(0, 1, 5'd1, 32'hA0A0_0001);
    set_src(1, 1, 5'd2, 32'hB0B0_0002);
    set_src(2, 1, 5'd3, 32'hC0C0_0003);
    step();
    chk("reset_ready", 64'(srcReady), 64'd0);
    step();
    chk("reset_wctrl", 64'(wCtrl), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);

    // Contention from ptr=0: 0,1,2,0,1,2
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("contention_grant", 64'(srcReady), 64'(order[c]));
      step();
      chk("contention_sel", 64'(wSel), 64'(c % 3 + 1));
      chk("contention_wctrl", 64'(wCtrl), 64'd1);
    end
    srcValid = '0;
    step();

    // Single write from the load unit
    set_src(1, 1, 5'd5, 32'hDEAD_BEEF);
    step();
    chk("single_wctrl", 64'(wCtrl), 64'd1);
    chk("single_wsel", 64'(wSel), 64'd5);
    chk("single_wdata", 64'(wData), 64'hDEAD_BEEF);
    srcValid = '0;
    step();
    chk("single_after", 64'(wCtrl), 64'd0);

    // Writes to x0 are consumed but never reach the register file
    set_src(0, 1, 5'd0, 32'h0000_1234);
    #1;
    chk("x0_ready", 64'(srcReady[0]), 64'd1);
    step();
    chk("x0_wctrl", 64'(wCtrl), 64'd0);
    chk("x0_busy0", 64'(busy[0]), 64'd0);
    srcValid = '0;

    // Scoreboard set, clear, and set-wins-over-clear
    issueValid = 1'b1; issueRd = 5'd7;
    step();
    chk("sb_set", 64'(busy[7]), 64'd1);
    issueValid = 1'b0;
    set_src(2, 1, 5'd7, 32'h7777_7777);
    step();
    chk("sb_still_busy", 64'(busy[7]), 64'd1);
    srcValid = '0;
    step();
    chk("sb_clear", 64'(busy[7]), 64'd0);
    issueValid = 1'b1;
    step();
    issueValid = 1'b0;
    set_src(2, 1, 5'd7, 32'h7070_7070);
    step();
    srcValid = '0; issueValid = 1'b1;
    step();
    chk("sb_set_wins", 64'(busy[7]), 64'd1);
    issueValid = 1'b0;

    // Reset while a write sits in the output stage
    set_src(2, 1, 5'd9, 32'h9999_0000);
    issueValid = 1'b1; issueRd = 5'd9;
    step();
    srcValid = '0; issueValid = 1'b0; rst = 1'b0;
    step();
    chk("midrst_wctrl", 64'(wCtrl), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    srcValid = 3'b111;
    #1;
    chk("midrst_ptr", 64'(srcReady), 64'b001);
    step();

    // Randomized traffic with sources holding requests until transferred
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NS; i++) begin
        if (!srcValid[i] || last_g == i) begin
          set_src(i, ($urandom_range(0, 2) != 0), RS'($urandom_range(0, NR - 1)), W'($urandom));
        end
      end
      issueValid = ($urandom_range(0, 1) == 1);
      issueRd    = RS'($urandom_range(0, NR - 1));
      rst        = ($urandom_range(0, 49) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and register scoreboard for the integer register file. It collects writeback requests from `NUM_SRC` producers (ALU, load unit, CSR unit), grants one per cycle by round-robin, and drives the register file's single write port from a registered output stage. It also keeps a per-register busy scoreboard so the issue stage can stall on registers that still have a write pending.

## Interface
Parameters:
- `WORD_SIZE`, default 32: data width.
- `NUM_REGS`, default 32: number of architectural registers.
- `REG_SEL`, default `$clog2(NUM_REGS)`: register index width.
- `NUM_SRC`, default 3: number of writeback requesters (≥2). Index 0 is ALU, 1 is load, 2 is CSR.

Ports:
- `clk`, input, 1: clock. Everything is rising-edge.
- `rst`, input, 1: reset. One clock; reset is synchronous and active-low.
- `srcValid`, input, `NUM_SRC`: per-source write request.
- `srcSel`, input, `NUM_SRC*REG_SEL`: per-source destination register. Source i occupies `[i*REG_SEL +: REG_SEL]`.
- `srcData`, input, `NUM_SRC*WORD_SIZE`: per-source write data, packed the same way.
- `srcReady`, output, `NUM_SRC`: one-hot grant, combinational.
- `issueValid`, input, 1: an instruction with a destination register is issuing this cycle.
- `issueRd`, input, `REG_SEL`: that instruction's destination.
- `busy`, output, `NUM_REGS`: scoreboard, registered. Bit 0 is always 0.
- `wCtrl`, output, 1: register file write enable, registered.
- `wSel`, output, `REG_SEL`: register file write index, registered.
- `wData`, output, `WORD_SIZE`: register file write data, registered.

## Operation
- **Handshake.** Source i transfers in a cycle where `srcValid[i]` and `srcReady[i]` are both high.
  - A source must hold `srcValid`, `srcSel` and `srcData` stable until that transfer.
  - `srcReady` never depends on `srcSel` or `srcData`.
- **Arbitration.** Round-robin pointer `ptr`, range 0..NUM_SRC-1, reset value 0.
  - Search order is `ptr`, `ptr+1`, … modulo NUM_SRC. The first valid source found is granted.
  - At most one grant per cycle.
  - After a grant to source g, `ptr <= (g+1) mod NUM_SRC`.
  - With no valid source, `ptr` holds and `srcReady` is all zero.
- **Output stage.** On a grant: `wCtrl <= (sel != 0)`, `wSel <= sel`, `wData <= data`.
  - With no grant, `wCtrl <= 0`; `wSel` and `wData` hold their values.
- **x0 writes.** Writes to register 0 are accepted (the source sees ready) but never reach the register file.
- **Scoreboard.**
  - `issueValid` with `issueRd != 0` sets `busy[issueRd]`.
  - A cycle with `wCtrl` high clears `busy[wSel]`, on the same edge the register file captures the write.
  - If a set and a clear hit the same index on the same edge, the set wins.
  - `busy[0]` is held at 0.
- **Stall responsibility.** The issue stage stalls while `busy[rs1]` or `busy[rs2]` is set. This block does not stall anything itself.
- **Reset (`rst` low at an edge).** All outputs go to zero: `wCtrl=0`, `wSel=0`, `wData=0`, `busy=0`, `ptr=0`.
  - A write sitting in the output stage is dropped.
  - `srcReady` is forced to 0 while `rst` is low, so no request is consumed during reset.

## Timing
- **Latency.** A grant in cycle N shows `wCtrl` high in cycle N+1. The register file commits at the end of N+1, and the written value is readable in N+2.
- **Busy.** `busy` reflects sets and clears one cycle after the cause.
- **Throughput.** One write per cycle. Back-to-back grants are allowed.
- **Fairness.** With all sources continuously valid, each is granted once every NUM_SRC cycles.
- **Combinational path.** The only combinational path is `srcValid`/`ptr`/`rst` → `srcReady`.

## Structure
- Shared package `rv_pkg`: `WORD_SIZE`, `NUM_REGS`, `REG_SEL`, and source-index constants `SRC_ALU=0`, `SRC_LOAD=1`, `SRC_CSR=2`.
- Sub-module `rr_arbiter` (parameter `N`; ports `req`, `grant`, `ptr` update): the round-robin grant logic, reusable for the future memory-port arbiter.
- Scoreboard and output register stay inline.

## Test plan
- **Reset.** Hold `rst=0` for 2 cycles with all `srcValid=1`. Required: `srcReady=0`, `wCtrl=0`, `busy=0`. Release: first grant goes to source 0.
- **Single write.** Source 1 writes sel=5, data=0xDEADBEEF in cycle N. Required: in cycle N+1, `wCtrl=1`, `wSel=5`, `wData=0xDEADBEEF`; in cycle N+2, `wCtrl=0`.
- **Contention.** All three sources held valid for 6 cycles, starting from `ptr=0`. Required grant order: 0,1,2,0,1,2, with one `wCtrl` pulse per cycle carrying each source's data.
- **x0.** Source 0 writes sel=0, data=0x1234. Required: `srcReady[0]=1`; in cycle N+1, `wCtrl=0`; `busy[0]=0` throughout.
- **Scoreboard.**
  - Issue rd=7 in cycle N: `busy[7]=1` in N+1.
  - Source 2 writes sel=7 in cycle M: `busy[7]=0` in M+2.
  - Issue rd=7 in the same cycle its clear takes effect: `busy[7]` stays 1.
- **Reset mid-operation.** Grant source 2 in cycle N, then drive `rst=0` in cycle N+1. Required: `wCtrl=0` from N+2 onward, `busy=0`, `ptr=0`.
